// File: rtl/display_arbiter_pkg.sv
// Shared types and source-index constants for the 7-segment display arbiter.
package display_arb_pkg;

    typedef enum logic {
        ST_BASE = 1'b0,
        ST_OVR  = 1'b1
    } state_t;

    typedef logic [1:0] src_idx_t;

    localparam src_idx_t SRC_SCORE   = 2'd0;
    localparam src_idx_t SRC_TIMER   = 2'd1;
    localparam src_idx_t SRC_DIFF    = 2'd2;
    localparam src_idx_t SRC_HISCORE = 2'd3;

endpackage

// File: rtl/display_arbiter_if.sv
// Source-side and display-side signals of the display arbiter, bundled as one port.
interface display_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int VAL_W   = 8
);
    import display_arb_pkg::*;

    src_idx_t                   base_sel;
    logic [NUM_SRC*VAL_W-1:0]   src_val;
    logic [NUM_SRC-1:0]         src_req;
    logic [NUM_SRC-1:0]         src_blink;
    logic [VAL_W-1:0]           disp_value;
    logic                       disp_blank;
    src_idx_t                   disp_src;
    logic                       busy;

    modport master (
        output base_sel, src_val, src_req, src_blink,
        input  disp_value, disp_blank, disp_src, busy
    );

    modport slave (
        input  base_sel, src_val, src_req, src_blink,
        output disp_value, disp_blank, disp_src, busy
    );

endinterface

// File: rtl/display_arbiter_tick_timer.sv
// Loadable down-counter that stops at zero; expire_o flags the zero count while enabled.
module tick_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q;

    assign expire_o = en_i && (count_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && count_q != '0) begin
            count_q <= count_q - ONE;
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Time-shares the two-digit display between a background source and prioritised,
// time-limited override requests; all outputs are registered.
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int VAL_W       = 8,
    parameter int MAX_VAL     = 99,
    parameter int HOLD_TICKS  = 100_000_000,
    parameter int BLINK_TICKS = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    display_arbiter_if.slave  bus
);

    localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
    localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_TICKS - 1);
    localparam logic [VAL_W-1:0]   SAT_VAL    = VAL_W'(MAX_VAL);

    state_t             state_q, state_d;
    src_idx_t           grant_q, grant_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               phase_q, phase_d;
    logic [VAL_W-1:0]   disp_value_q, disp_value_d;
    logic               disp_blank_q, disp_blank_d;
    src_idx_t           disp_src_q, disp_src_d;
    logic               busy_q, busy_d;

    logic               hold_load, blink_load;
    logic               hold_expire, blink_expire;
    logic               in_ovr;
    logic [NUM_SRC-1:0] below, above, req_lo, cand;
    logic [VAL_W-1:0]   vals [NUM_SRC];

    function automatic src_idx_t safe_idx(input src_idx_t idx);
        return (int'(idx) >= NUM_SRC) ? SRC_SCORE : idx;
    endfunction

    function automatic src_idx_t lowest(input logic [NUM_SRC-1:0] v);
        src_idx_t r;
        r = SRC_SCORE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) r = src_idx_t'(i);
        end
        return r;
    endfunction

    function automatic logic [NUM_SRC-1:0] onehot(input src_idx_t idx);
        logic [NUM_SRC-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(idx) == i) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [VAL_W-1:0] sat(input logic [VAL_W-1:0] v);
        return (v > SAT_VAL) ? SAT_VAL : v;
    endfunction

    assign in_ovr = (state_q == ST_OVR);

    tick_timer #(.W(HOLD_W)) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load_i     (hold_load),
        .load_val_i (HOLD_LOAD),
        .en_i       (in_ovr),
        .expire_o   (hold_expire)
    );

    tick_timer #(.W(BLINK_W)) u_blink (
        .clk        (clk),
        .reset      (reset),
        .load_i     (blink_load),
        .load_val_i (BLINK_LOAD),
        .en_i       (in_ovr),
        .expire_o   (blink_expire)
    );

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            vals[i]  = bus.src_val[i*VAL_W +: VAL_W];
            below[i] = (i < int'(grant_q));
            above[i] = (i > int'(grant_q));
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        pending_d  = pending_q;
        phase_d    = phase_q;
        hold_load  = 1'b0;
        blink_load = 1'b0;
        req_lo     = bus.src_req & below;
        cand       = pending_q | bus.src_req;

        case (state_q)
            ST_BASE: begin
                if (|bus.src_req) begin
                    state_d    = ST_OVR;
                    grant_d    = lowest(bus.src_req);
                    pending_d  = bus.src_req & ~onehot(grant_d);
                    hold_load  = 1'b1;
                    blink_load = 1'b1;
                    phase_d    = 1'b0;
                end
            end
            ST_OVR: begin
                if (|req_lo) begin
                    // Preempted owner is dropped, not re-queued.
                    grant_d    = lowest(req_lo);
                    pending_d  = pending_q | (bus.src_req & ~onehot(grant_d) & ~onehot(grant_q));
                    hold_load  = 1'b1;
                    blink_load = 1'b1;
                    phase_d    = 1'b0;
                end else if (hold_expire) begin
                    if (|cand) begin
                        grant_d    = lowest(cand);
                        pending_d  = cand & ~onehot(grant_d);
                        hold_load  = 1'b1;
                        blink_load = 1'b1;
                    end else begin
                        state_d   = ST_BASE;
                        pending_d = '0;
                    end
                    phase_d = 1'b0;
                end else begin
                    pending_d = pending_q | (bus.src_req & above);
                    hold_load = bus.src_req[grant_q];
                    if (blink_expire) begin
                        phase_d    = ~phase_q;
                        blink_load = 1'b1;
                    end
                end
            end
            default: state_d = ST_BASE;
        endcase

        // Outputs are derived from next state so a request shows one cycle later.
        busy_d       = (state_d == ST_OVR);
        disp_src_d   = busy_d ? grant_d : safe_idx(bus.base_sel);
        disp_value_d = sat(vals[disp_src_d]);
        disp_blank_d = busy_d && phase_d && bus.src_blink[grant_d];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BASE;
            grant_q      <= SRC_SCORE;
            pending_q    <= '0;
            phase_q      <= 1'b0;
            disp_value_q <= '0;
            disp_blank_q <= 1'b0;
            disp_src_q   <= SRC_SCORE;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            pending_q    <= pending_d;
            phase_q      <= phase_d;
            disp_value_q <= disp_value_d;
            disp_blank_q <= disp_blank_d;
            disp_src_q   <= disp_src_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.disp_value = disp_value_q;
    assign bus.disp_blank = disp_blank_q;
    assign bus.disp_src   = disp_src_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed scoreboard bench for display_arbiter with short hold/blink periods.
module tb_display_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    typedef struct {
        int    value;
        int    blank;
        int    src;
        int    busy;
        string tag;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    display_arbiter_if #(.NUM_SRC(4), .VAL_W(8)) bus ();

    display_arbiter #(
        .NUM_SRC     (4),
        .VAL_W       (8),
        .MAX_VAL     (99),
        .HOLD_TICKS  (10),
        .BLINK_TICKS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic cmp(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        e = sb_q.pop_front();
        cmp(e.tag, "value", 32'(bus.disp_value), e.value);
        cmp(e.tag, "blank", 32'(bus.disp_blank), e.blank);
        cmp(e.tag, "src",   32'(bus.disp_src),   e.src);
        cmp(e.tag, "busy",  32'(bus.busy),       e.busy);
    endtask

    task automatic push(input int v, input int b, input int s, input int bz, input string tag);
        exp_t e;
        e.value = v; e.blank = b; e.src = s; e.busy = bz; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic check_now(input int v, input int b, input int s, input int bz, input string tag);
        push(v, b, s, bz, tag);
        check_out();
    endtask

    task automatic cyc(input int v, input int b, input int s, input int bz, input string tag);
        push(v, b, s, bz, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic run(input int n, input int v, input int s, input int bz, input string tag);
        repeat (n) cyc(v, 0, s, bz, tag);
    endtask

    task automatic set_val(input int i, input int v);
        bus.src_val[i*8 +: 8] = 8'(v);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.base_sel  = 2'd1;
        bus.src_val   = '0;
        bus.src_req   = '0;
        bus.src_blink = '0;
        set_val(0, 11);
        set_val(1, 42);
        set_val(2, 7);
        set_val(3, 120);

        // Reset values and one-cycle latency to the background source.
        #1;
        check_now(0, 0, 0, 0, "reset_t0");
        repeat (2) @(posedge clk);
        #1;
        check_now(0, 0, 0, 0, "reset_held");
        reset = 1'b0;
        cyc(42, 0, 1, 0, "t1_base");
        set_val(1, 150);  cyc(99, 0, 1, 0, "t1_sat150");
        set_val(1, 99);   cyc(99, 0, 1, 0, "t1_sat99");
        set_val(1, 100);  cyc(99, 0, 1, 0, "t1_sat100");
        set_val(1, 42);   cyc(42, 0, 1, 0, "t1_back42");
        bus.base_sel = 2'd0; cyc(11, 0, 0, 0, "t1_sel0");
        bus.base_sel = 2'd1; cyc(42, 0, 1, 0, "t1_sel1");

        // Single override lasting exactly 10 cycles, with a live value update.
        bus.src_req = 4'b0100; cyc(7, 0, 2, 1, "t2_grant");
        bus.src_req = 4'b0000;
        run(4, 7, 2, 1, "t2_hold");
        set_val(2, 8);
        run(5, 8, 2, 1, "t2_live");
        cyc(42, 0, 1, 0, "t2_expire");
        set_val(2, 7);

        // Queue a lower-priority request, then preempt with source 0.
        bus.src_req = 4'b0100; cyc(7, 0, 2, 1, "t3_c1");
        bus.src_req = 4'b0000;
        run(2, 7, 2, 1, "t3_c2_3");
        bus.src_req = 4'b1000; cyc(7, 0, 2, 1, "t3_c5");
        bus.src_req = 4'b0000; cyc(7, 0, 2, 1, "t3_c6");
        bus.src_req = 4'b0001; cyc(11, 0, 0, 1, "t3_pre0");
        bus.src_req = 4'b0000;
        run(9, 11, 0, 1, "t3_hold0");
        run(10, 99, 3, 1, "t3_hold3");
        cyc(42, 0, 1, 0, "t3_base");

        // Simultaneous requests: lowest wins, the other follows.
        bus.src_req = 4'b1010; cyc(42, 0, 1, 1, "t4_grant1");
        bus.src_req = 4'b0000;
        run(9, 42, 1, 1, "t4_hold1");
        run(10, 99, 3, 1, "t4_hold3");
        run(2, 42, 1, 0, "t4_base");

        // Blink phase pattern while source 2 holds the display.
        bus.src_blink = 4'b0100;
        bus.src_req   = 4'b0100; cyc(7, 0, 2, 1, "t5_b1");
        bus.src_req   = 4'b0000;
        cyc(7, 0, 2, 1, "t5_b2");
        cyc(7, 0, 2, 1, "t5_b3");
        cyc(7, 1, 2, 1, "t5_b4");
        cyc(7, 1, 2, 1, "t5_b5");
        cyc(7, 1, 2, 1, "t5_b6");
        cyc(7, 0, 2, 1, "t5_b7");
        cyc(7, 0, 2, 1, "t5_b8");
        cyc(7, 0, 2, 1, "t5_b9");
        cyc(7, 1, 2, 1, "t5_b10");
        cyc(42, 0, 1, 0, "t5_base");
        bus.src_blink = 4'b0000;

        // Asynchronous reset mid-override with a pending request outstanding.
        bus.src_req = 4'b0100; cyc(7, 0, 2, 1, "t6_c1");
        bus.src_req = 4'b1000; cyc(7, 0, 2, 1, "t6_c2");
        bus.src_req = 4'b0000;
        run(3, 7, 2, 1, "t6_c3_5");
        reset = 1'b1;
        #1;
        check_now(0, 0, 0, 0, "t6_async");
        @(posedge clk);
        #1;
        check_now(0, 0, 0, 0, "t6_held");
        reset = 1'b0;
        cyc(42, 0, 1, 0, "t6_base");
        bus.src_req = 4'b0100; cyc(7, 0, 2, 1, "t6_regrant");
        bus.src_req = 4'b0000;
        run(9, 7, 2, 1, "t6_hold2");
        run(2, 42, 1, 0, "t6_no_pending");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
